// File: rtl/bnn_seq_engine.sv
// Time-multiplexed two-layer XNOR-popcount BNN: one neuron per clock, start/done handshake, nibble-serial weight load.
// Optional per-neuron loadable thresholds are enabled by defining BNN_PROG_THRESH_EN.
module bnn_seq_engine #(
  parameter int WIDTH  = 8,
  parameter int N_OUT  = 4,
  parameter int LOAD_W = 4,
  parameter int THRESH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [WIDTH-1:0]  x_in,
  input  logic              start,
  input  logic              load_en,
  input  logic [LOAD_W-1:0] load_data,
  output logic              busy,
  output logic              done,
  output logic [N_OUT-1:0]  result,
  output logic [WIDTH-1:0]  hidden,
  output logic              load_wrap
);
  localparam int NN     = WIDTH + N_OUT;
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int WBEATS = WIDTH / LOAD_W;
`ifdef BNN_PROG_THRESH_EN
  localparam int TW     = LOAD_W * ((CW + LOAD_W - 1) / LOAD_W);
`else
  localparam int TW     = 0;
`endif
  localparam int BEATS  = WBEATS + TW / LOAD_W;
  localparam int RW     = BEATS * LOAD_W;
  localparam int IW     = $clog2(NN);
  localparam int XW     = $clog2(WIDTH);
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int KW     = (TW > CW) ? TW : CW;

  localparam logic [XW-1:0] L1_LAST   = XW'(WIDTH - 1);
  localparam logic [XW-1:0] L2_LAST   = XW'(N_OUT - 1);
  localparam logic [IW-1:0] LOAD_LAST = IW'(NN - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L1   = 2'd1,
    S_L2   = 2'd2
  } state_t;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic neuron_fire(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] w,
                                       input logic [KW-1:0]    thr);
    return KW'(popcount(~(a ^ w))) >= thr;
  endfunction

  state_t            state_r;
  logic [WIDTH-1:0]  w_r [NN];
`ifdef BNN_PROG_THRESH_EN
  logic [TW-1:0]     t_r [NN];
`endif
  logic [WIDTH-1:0]  x_r;
  logic [XW-1:0]     idx_r;
  logic [N_OUT-1:0]  shadow_r;
  logic [IW-1:0]     lidx_r;
  logic [BW-1:0]     beat_r;
  logic [RW-1:0]     stage_r;

  logic [IW-1:0]     nidx_s;
  logic [WIDTH-1:0]  op_s;
  logic [KW-1:0]     thr_s;
  logic              fire_s;
  logic [N_OUT-1:0]  shadow_s;
  logic [RW-1:0]     rec_s;

  // Shared neuron datapath, shadow update and load-record assembly
  always_comb begin
    nidx_s = IW'(idx_r);
    op_s   = x_r;
    if (state_r == S_L2) begin
      nidx_s = IW'(idx_r) + IW'(WIDTH);
      op_s   = hidden;
    end else begin
      nidx_s = IW'(idx_r);
      op_s   = x_r;
    end
`ifdef BNN_PROG_THRESH_EN
    thr_s = KW'(t_r[nidx_s]);
`else
    thr_s = KW'(THRESH);
`endif
    fire_s   = neuron_fire(op_s, w_r[nidx_s], thr_s);
    shadow_s = shadow_r;
    for (int i = 0; i < N_OUT; i++) begin
      if (idx_r == XW'(i)) shadow_s[i] = fire_s;
      else                 shadow_s[i] = shadow_r[i];
    end
    rec_s = stage_r;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_r == BW'(k)) rec_s[k*LOAD_W +: LOAD_W] = load_data;
      else                  rec_s[k*LOAD_W +: LOAD_W] = stage_r[k*LOAD_W +: LOAD_W];
    end
  end

  // Control FSM, weight store, load counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      for (int n = 0; n < NN; n++) begin
        w_r[n] <= '0;
`ifdef BNN_PROG_THRESH_EN
        t_r[n] <= TW'(THRESH);
`endif
      end
      x_r       <= '0;
      idx_r     <= '0;
      shadow_r  <= '0;
      lidx_r    <= '0;
      beat_r    <= '0;
      stage_r   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      hidden    <= '0;
      load_wrap <= 1'b0;
    end else begin
      done      <= 1'b0;
      load_wrap <= 1'b0;
      if (ena) begin
        case (state_r)
          S_IDLE: begin
            // A load beat always wins over a simultaneous start
            if (load_en) begin
              if (beat_r == BEAT_LAST) begin
                w_r[lidx_r] <= rec_s[WIDTH-1:0];
`ifdef BNN_PROG_THRESH_EN
                t_r[lidx_r] <= rec_s[RW-1 -: TW];
`endif
                beat_r <= '0;
                if (lidx_r == LOAD_LAST) begin
                  lidx_r    <= '0;
                  load_wrap <= 1'b1;
                end else begin
                  lidx_r <= lidx_r + IW'(1);
                end
              end else begin
                stage_r <= rec_s;
                beat_r  <= beat_r + BW'(1);
              end
            end else if (start && (beat_r == '0)) begin
              x_r     <= x_in;
              idx_r   <= '0;
              busy    <= 1'b1;
              state_r <= S_L1;
            end else begin
              state_r <= S_IDLE;
            end
          end
          S_L1: begin
            hidden[idx_r] <= fire_s;
            if (idx_r == L1_LAST) begin
              idx_r   <= '0;
              state_r <= S_L2;
            end else begin
              idx_r <= idx_r + XW'(1);
            end
          end
          S_L2: begin
            shadow_r <= shadow_s;
            if (idx_r == L2_LAST) begin
              result  <= shadow_s;
              done    <= 1'b1;
              busy    <= 1'b0;
              idx_r   <= '0;
              state_r <= S_IDLE;
            end else begin
              idx_r <= idx_r + XW'(1);
            end
          end
          default: begin
            busy    <= 1'b0;
            idx_r   <= '0;
            state_r <= S_IDLE;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end
endmodule

// File: tb/tb_bnn_seq_engine.sv
// Scoreboard bench for bnn_seq_engine: expected {hidden,result} pushed at each start, popped on done.
module tb_bnn_seq_engine;
  localparam int WIDTH  = 8;
  localparam int N_OUT  = 4;
  localparam int LOAD_W = 4;
  localparam int THRESH = 6;
  localparam int NN     = WIDTH + N_OUT;
`ifdef BNN_PROG_THRESH_EN
  localparam int BPN = 3;
`else
  localparam int BPN = 2;
`endif

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b1;
  logic              ena       = 1'b0;
  logic              start     = 1'b0;
  logic              load_en   = 1'b0;
  logic [WIDTH-1:0]  x_in      = '0;
  logic [LOAD_W-1:0] load_data = '0;
  logic              busy, done, load_wrap;
  logic [N_OUT-1:0]  result;
  logic [WIDTH-1:0]  hidden;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0]       mw [NN];
  int                     ld_idx = 0;
  logic [WIDTH+N_OUT-1:0] exp_q [$];
  logic [WIDTH+N_OUT-1:0] mon_e;

  bnn_seq_engine #(.WIDTH(WIDTH), .N_OUT(N_OUT), .LOAD_W(LOAD_W), .THRESH(THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .x_in(x_in), .start(start),
    .load_en(load_en), .load_data(load_data), .busy(busy), .done(done),
    .result(result), .hidden(hidden), .load_wrap(load_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH+N_OUT-1:0] model(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] h;
    logic [N_OUT-1:0] r;
    int pc;
    for (int n = 0; n < WIDTH; n++) begin
      pc = 0;
      for (int b = 0; b < WIDTH; b++) if (x[b] == mw[n][b]) pc++;
      h[n] = (pc >= THRESH);
    end
    for (int n = 0; n < N_OUT; n++) begin
      pc = 0;
      for (int b = 0; b < WIDTH; b++) if (h[b] == mw[WIDTH+n][b]) pc++;
      r[n] = (pc >= THRESH);
    end
    return {h, r};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done hidden=%h result=%h", hidden, result);
      end else begin
        mon_e = exp_q.pop_front();
        if ({hidden, result} !== mon_e) begin
          errors++;
          $display("FAIL eval_result got hidden=%h result=%h expected hidden=%h result=%h",
                   hidden, result, mon_e[WIDTH+N_OUT-1:N_OUT], mon_e[N_OUT-1:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; load_en = 1'b0;
    for (int i = 0; i < NN; i++) mw[i] = '0;
    ld_idx = 0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic beat(input logic [LOAD_W-1:0] d);
    load_en = 1'b1; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic load_neuron(input logic [WIDTH-1:0] w);
    beat(w[3:0]);
    beat(w[7:4]);
`ifdef BNN_PROG_THRESH_EN
    beat(4'(THRESH));
`endif
    mw[ld_idx] = w;
    ld_idx = (ld_idx + 1) % NN;
  endtask

  task automatic start_eval(input logic [WIDTH-1:0] x);
    x_in = x; start = 1'b1;
    exp_q.push_back(model(x));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    ena = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, load_wrap} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b required 000", {busy, done, load_wrap});
    end
    checks++;
    if (result !== 4'h0) begin errors++; $display("FAIL reset_result got %h required 0", result); end
    checks++;
    if (hidden !== 8'h00) begin errors++; $display("FAIL reset_hidden got %h required 00", hidden); end
    do_reset();
  endtask

  task automatic test_default_eval();
    int lat, bcnt;
    x_in = 8'h00; start = 1'b1;
    exp_q.push_back(model(8'h00));
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 12) begin errors++; $display("FAIL latency got %0d required 12", lat); end
    checks++;
    if (bcnt != 12) begin errors++; $display("FAIL busy_cycles got %0d required 12", bcnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b required 0", busy); end
    checks++;
    if (hidden !== 8'hFF || result !== 4'h0) begin
      errors++; $display("FAIL default_x00 got %h/%h required ff/0", hidden, result);
    end
    @(negedge clk);
    start_eval(8'hFF);
    wait_done();
    checks++;
    if (hidden !== 8'h00 || result !== 4'hF) begin
      errors++; $display("FAIL default_xff got %h/%h required 00/f", hidden, result);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (result !== 4'hF || done !== 1'b0) begin
      errors++; $display("FAIL result_hold got %h done=%b required f done=0", result, done);
    end
  endtask

  task automatic test_load_weights();
    load_neuron(8'hA0);
    start_eval(8'h5F);
    wait_done();
    checks++;
    if (hidden !== 8'h00 || result !== 4'hF) begin
      errors++; $display("FAIL load_x5f got %h/%h required 00/f", hidden, result);
    end
    start_eval(8'hA0);
    wait_done();
    checks++;
    if (hidden[0] !== 1'b1) begin errors++; $display("FAIL load_xa0_bit0 got %b required 1", hidden[0]); end
  endtask

  task automatic test_load_wrap();
    logic exp_w;
    do_reset();
    for (int i = 0; i < NN * BPN; i++) begin
      beat(((i % BPN) >= 2) ? 4'(THRESH) : 4'h0);
      exp_w = (i == NN * BPN - 1);
      checks++;
      if (load_wrap !== exp_w) begin
        errors++; $display("FAIL load_wrap beat=%0d got %b required %b", i + 1, load_wrap, exp_w);
      end
    end
    load_neuron(8'h0F);
    checks++;
    if (load_wrap !== 1'b0) begin errors++; $display("FAIL wrap_repeat got %b required 0", load_wrap); end
    start_eval(8'h00);
    wait_done();
    checks++;
    if (hidden !== 8'hFE) begin errors++; $display("FAIL wrap_neuron0 got %h required fe", hidden); end
  endtask

  task automatic test_busy_ignore();
    start_eval(8'h3C);
    load_en = 1'b1; load_data = 4'hF; start = 1'b1; x_in = 8'hFF;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_during_noise got %b required 1", busy); end
    load_en = 1'b0; start = 1'b0;
    wait_done();
    load_neuron(8'h96);
    start_eval(8'h69);
    wait_done();
  endtask

  task automatic test_start_refused();
    int bad;
    beat(4'h3);
    x_in = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    repeat (3) begin
      if (busy !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL start_refused busy_cycles=%0d required 0", bad); end
    beat(4'h5);
`ifdef BNN_PROG_THRESH_EN
    beat(4'(THRESH));
`endif
    mw[ld_idx] = 8'h53;
    ld_idx = (ld_idx + 1) % NN;
    start_eval(8'hC3);
    wait_done();
  endtask

  task automatic test_ena_freeze();
    int bad, n;
    start_eval(8'h5A);
    repeat (3) @(negedge clk);
    ena = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ena_freeze bad_cycles=%0d required 0", bad); end
    ena = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 9) begin errors++; $display("FAIL ena_resume_latency got %0d required 9", n); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_eval();
    int bad;
    do_reset();
    start_eval(8'hFF);
    wait_done();
    x_in = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 4'h0) begin
      errors++; $display("FAIL reset_mid got busy=%b done=%b result=%h required 0/0/0", busy, done, result);
    end
    for (int i = 0; i < NN; i++) mw[i] = '0;
    ld_idx = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_mid_done got %0d required 0", bad); end
    start_eval(8'h77);
    wait_done();
  endtask

  task automatic test_back_to_back();
    int n, lat;
    start_eval(8'h00);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b required 1", done); end
    x_in = 8'hFF; start = 1'b1;
    exp_q.push_back(model(8'hFF));
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 12) begin errors++; $display("FAIL b2b_latency got %0d required 12", lat); end
    wait_done();
  endtask

  initial begin
    test_reset();
    test_default_eval();
    test_load_weights();
    test_load_wrap();
    test_busy_ignore();
    test_start_refused();
    test_ena_freeze();
    test_reset_mid_eval();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
